// File: rtl/bell_led_ctrl_multi_57.sv
// Purpose : multi-channel alarm / hourly chime controller driving buzzer and LED.
// Latency : every output is registered; it reflects a causing input one clk_50m_57 cycle later.
// Backpres: none; sec_tick_57, stop_57 and snooze_57 are single-cycle pulses that are always consumed.
//
// Ports:
//   clk_50m_57, rst_57        clock and synchronous active-high reset
//   sec_tick_57               one pulse per second; now_* already carry the new second
//   now_sec/min/hour_57       current time, binary
//   alarm_sec/min/hour_57     packed per-channel alarm time, channel k at [7k+6:7k]
//   alarm_en_57               per-channel enable
//   chime_en_57               hourly chime enable
//   stop_57, snooze_57        user requests (one-cycle pulses)
//   sound_e_57                buzzer enable
//   sound_model_57            0 = alarm pattern, 1 = chime pattern
//   led_57                    indicator LED
//   active_idx_57             channel currently ringing or snoozed
//   snooze_cnt_57             snoozes used in the current alarm event

module bell_led_ctrl_multi_57 #(
    parameter int N_ALARM    = 4,
    parameter int RING_SEC   = 30,
    parameter int SNOOZE_SEC = 300,
    parameter int CHIME_SEC  = 5,
    parameter int MAX_SNOOZE = 3,
    parameter int IDX_W      = 2
) (
    input  logic                   clk_50m_57,
    input  logic                   rst_57,
    input  logic                   sec_tick_57,
    input  logic [6:0]             now_sec_57,
    input  logic [6:0]             now_min_57,
    input  logic [6:0]             now_hour_57,
    input  logic [7*N_ALARM-1:0]   alarm_sec_57,
    input  logic [7*N_ALARM-1:0]   alarm_min_57,
    input  logic [7*N_ALARM-1:0]   alarm_hour_57,
    input  logic [N_ALARM-1:0]     alarm_en_57,
    input  logic                   chime_en_57,
    input  logic                   stop_57,
    input  logic                   snooze_57,
    output logic                   sound_e_57,
    output logic                   sound_model_57,
    output logic                   led_57,
    output logic [IDX_W-1:0]       active_idx_57,
    output logic [2:0]             snooze_cnt_57
);

    // Counter is wide enough for the longest of the three timed states.
    localparam int MAX_T_A = (RING_SEC > SNOOZE_SEC) ? RING_SEC : SNOOZE_SEC;
    localparam int MAX_T   = (MAX_T_A > CHIME_SEC) ? MAX_T_A : CHIME_SEC;
    localparam int CNT_W   = $clog2(MAX_T + 1);

    localparam logic [CNT_W-1:0] RING_LD   = CNT_W'(RING_SEC);
    localparam logic [CNT_W-1:0] SNOOZE_LD = CNT_W'(SNOOZE_SEC);
    localparam logic [CNT_W-1:0] CHIME_LD  = CNT_W'(CHIME_SEC);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
    localparam logic [2:0]       SNZ_MAX   = 3'(MAX_SNOOZE);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ALARM  = 2'd1,
        ST_SNOOZE = 2'd2,
        ST_CHIME  = 2'd3
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [2:0]       snz_q, snz_d;
    logic             model_q, model_d;
    logic             led_q, led_d;
    logic             sound_q, sound_d;

    // ------------------------------------------------------------------
    // Alarm comparison: scan from the top so the lowest matching channel
    // is the last one written and therefore wins.
    // ------------------------------------------------------------------
    logic             match_any;
    logic [IDX_W-1:0] match_idx;

    always_comb begin
        match_any = 1'b0;
        match_idx = '0;
        for (int k = N_ALARM - 1; k >= 0; k--) begin
            if (alarm_en_57[k] &&
                (alarm_sec_57[7*k +: 7]  == now_sec_57) &&
                (alarm_min_57[7*k +: 7]  == now_min_57) &&
                (alarm_hour_57[7*k +: 7] == now_hour_57)) begin
                match_any = 1'b1;
                match_idx = IDX_W'(k);
            end
        end
    end

    logic tick_match;
    logic chime_hit;
    logic active_en;
    logic cnt_last;

    assign tick_match = sec_tick_57 && match_any;
    assign chime_hit  = sec_tick_57 && chime_en_57 &&
                        (now_min_57 == 7'd0) && (now_sec_57 == 7'd0);
    assign active_en  = alarm_en_57[idx_q];
    assign cnt_last   = (cnt_q == CNT_ONE);

    // ------------------------------------------------------------------
    // Next-state logic. Branch order inside each state encodes the
    // same-cycle precedence: stop, then enable-clear, then snooze, then
    // tick-driven events (match / expiry).
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        snz_d   = snz_q;
        model_d = model_q;
        led_d   = led_q;

        unique case (state_q)
            ST_IDLE: begin
                // A stop on a tick cycle suppresses any trigger.
                if (!stop_57) begin
                    if (tick_match) begin
                        state_d = ST_ALARM;
                        cnt_d   = RING_LD;
                        idx_d   = match_idx;
                        snz_d   = 3'd0;
                        model_d = 1'b0;
                        led_d   = 1'b1;
                    end else if (chime_hit) begin
                        state_d = ST_CHIME;
                        cnt_d   = CHIME_LD;
                        model_d = 1'b1;
                        led_d   = 1'b1;
                    end
                end
            end

            ST_ALARM: begin
                if (stop_57 || !active_en) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                    led_d   = 1'b0;
                end else if (snooze_57) begin
                    if (snz_q < SNZ_MAX) begin
                        state_d = ST_SNOOZE;
                        cnt_d   = SNOOZE_LD;
                        snz_d   = snz_q + 3'd1;
                        led_d   = 1'b1;
                    end else begin
                        // Snooze budget exhausted: behaves as stop.
                        state_d = ST_IDLE;
                        cnt_d   = '0;
                        led_d   = 1'b0;
                    end
                end else if (sec_tick_57) begin
                    // New matches while ringing are deliberately ignored.
                    if (cnt_last) begin
                        state_d = ST_IDLE;
                        cnt_d   = '0;
                        led_d   = 1'b0;
                    end else begin
                        cnt_d = cnt_q - CNT_ONE;
                        led_d = ~led_q;
                    end
                end
            end

            ST_SNOOZE: begin
                if (stop_57 || !active_en) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                    led_d   = 1'b0;
                end else if (tick_match) begin
                    // A fresh alarm event takes over and restarts the snooze budget.
                    state_d = ST_ALARM;
                    cnt_d   = RING_LD;
                    idx_d   = match_idx;
                    snz_d   = 3'd0;
                    model_d = 1'b0;
                    led_d   = 1'b1;
                end else if (sec_tick_57) begin
                    if (cnt_last) begin
                        state_d = ST_ALARM;
                        cnt_d   = RING_LD;
                        model_d = 1'b0;
                        led_d   = 1'b1;
                    end else begin
                        cnt_d = cnt_q - CNT_ONE;
                    end
                end
            end

            ST_CHIME: begin
                if (stop_57) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                    led_d   = 1'b0;
                end else if (tick_match) begin
                    state_d = ST_ALARM;
                    cnt_d   = RING_LD;
                    idx_d   = match_idx;
                    snz_d   = 3'd0;
                    model_d = 1'b0;
                    led_d   = 1'b1;
                end else if (sec_tick_57) begin
                    if (cnt_last) begin
                        state_d = ST_IDLE;
                        cnt_d   = '0;
                        led_d   = 1'b0;
                    end else begin
                        cnt_d = cnt_q - CNT_ONE;
                        led_d = ~led_q;
                    end
                end
            end

            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
                led_d   = 1'b0;
            end
        endcase
    end

    // Buzzer follows the state being entered so it is aligned with led/model.
    always_comb begin
        sound_d = (state_d == ST_ALARM) || (state_d == ST_CHIME);
    end

    always_ff @(posedge clk_50m_57) begin
        if (rst_57) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            snz_q   <= 3'd0;
            model_q <= 1'b0;
            led_q   <= 1'b0;
            sound_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            snz_q   <= snz_d;
            model_q <= model_d;
            led_q   <= led_d;
            sound_q <= sound_d;
        end
    end

    assign sound_e_57     = sound_q;
    assign sound_model_57 = model_q;
    assign led_57         = led_q;
    assign active_idx_57  = idx_q;
    assign snooze_cnt_57  = snz_q;

endmodule

// File: tb/tb_bell_led_ctrl_multi_57.sv
// Purpose : directed bench for bell_led_ctrl_multi_57 with a cycle-tagged scoreboard.
// Latency : expectations are tagged with the cycle after the stimulus cycle.
// Backpres: none; the monitor consumes one expectation per tagged cycle.

module tb_bell_led_ctrl_multi_57;

    localparam int N_ALARM = 4;

    logic                 clk = 1'b0;
    logic                 rst = 1'b1;
    logic                 tick = 1'b0;
    logic                 stop = 1'b0;
    logic                 snz = 1'b0;
    logic [6:0]           now_s = '0;
    logic [6:0]           now_m = '0;
    logic [6:0]           now_h = '0;
    logic [7*N_ALARM-1:0] al_s = '0;
    logic [7*N_ALARM-1:0] al_m = '0;
    logic [7*N_ALARM-1:0] al_h = '0;
    logic [N_ALARM-1:0]   al_en = '0;
    logic                 ch_en = 1'b0;

    logic       sound_e;
    logic       sound_model;
    logic       led;
    logic [1:0] idx;
    logic [2:0] scnt;

    bell_led_ctrl_multi_57 #(
        .N_ALARM   (4),
        .RING_SEC  (3),
        .SNOOZE_SEC(4),
        .CHIME_SEC (2),
        .MAX_SNOOZE(2),
        .IDX_W     (2)
    ) dut (
        .clk_50m_57    (clk),
        .rst_57        (rst),
        .sec_tick_57   (tick),
        .now_sec_57    (now_s),
        .now_min_57    (now_m),
        .now_hour_57   (now_h),
        .alarm_sec_57  (al_s),
        .alarm_min_57  (al_m),
        .alarm_hour_57 (al_h),
        .alarm_en_57   (al_en),
        .chime_en_57   (ch_en),
        .stop_57       (stop),
        .snooze_57     (snz),
        .sound_e_57    (sound_e),
        .sound_model_57(sound_model),
        .led_57        (led),
        .active_idx_57 (idx),
        .snooze_cnt_57 (scnt)
    );

    always #10 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int         cyc;
        int         id;
        logic [7:0] v;   // {sound_e, model, led, idx[1:0], snooze_cnt[2:0]}
    } exp_t;

    exp_t exp_q[$];
    int   n_vec = 0;
    int   n_bad = 0;
    int   vid   = 0;

    // Monitor: compares DUT outputs against whatever expectation is due this cycle.
    always @(negedge clk) begin
        exp_t       e;
        logic [7:0] got;
        if (exp_q.size() > 0 && exp_q[0].cyc == cyc) begin
            e   = exp_q.pop_front();
            got = {sound_e, sound_model, led, idx, scnt};
            n_vec = n_vec + 1;
            if (got !== e.v) begin
                n_bad = n_bad + 1;
                $display("FAIL vec%0d: got se/sm/led/idx/sc=%b required %b", e.id, got, e.v);
            end
        end
    end

    function automatic logic [7:0] ex(input logic se, input logic sm, input logic ld,
                                      input int i, input int sc);
        logic [1:0] i2;
        logic [2:0] s3;
        i2 = 2'(i);
        s3 = 3'(sc);
        return {se, sm, ld, i2, s3};
    endfunction

    // One clock cycle of stimulus; called at a negedge, returns at the next negedge.
    task automatic step(input logic tk, input logic st, input logic sn, input logic [7:0] e);
        exp_t x;
        tick = tk;
        stop = st;
        snz  = sn;
        x.cyc = cyc + 1;
        x.id  = vid;
        x.v   = e;
        vid   = vid + 1;
        exp_q.push_back(x);
        @(negedge clk);
    endtask

    task automatic set_now(input int h, input int m, input int s);
        now_h = 7'(h);
        now_m = 7'(m);
        now_s = 7'(s);
    endtask

    task automatic set_alarm(input int k, input int h, input int m, input int s);
        al_h[7*k +: 7] = 7'(h);
        al_m[7*k +: 7] = 7'(m);
        al_s[7*k +: 7] = 7'(s);
    endtask

    initial begin
        @(negedge clk);
        // Reset state.
        step(0, 0, 0, ex(0, 0, 0, 0, 0));
        rst = 1'b0;

        // Single alarm on channel 2, full ring of 3 ticks.
        set_alarm(2, 7, 30, 0);
        al_en = 4'b0100;
        set_now(7, 29, 59); step(1, 0, 0, ex(0, 0, 0, 0, 0));
        set_now(7, 30, 0);  step(1, 0, 0, ex(1, 0, 1, 2, 0));
        set_now(7, 30, 1);  step(1, 0, 0, ex(1, 0, 0, 2, 0));
                            step(0, 0, 0, ex(1, 0, 0, 2, 0));
        set_now(7, 30, 2);  step(1, 0, 0, ex(1, 0, 1, 2, 0));
        set_now(7, 30, 3);  step(1, 0, 0, ex(0, 0, 0, 2, 0));

        // Two channels at the same time plus chime: lowest index wins, no chime.
        set_alarm(1, 6, 0, 0);
        set_alarm(3, 6, 0, 0);
        al_en = 4'b1010;
        ch_en = 1'b1;
        set_now(6, 0, 0);   step(1, 0, 0, ex(1, 0, 1, 1, 0));

        // Snooze twice, each time ringing again after 4 ticks; third snooze stops.
        step(0, 0, 1, ex(0, 0, 1, 1, 1));
        for (int t = 1; t <= 3; t++) begin
            set_now(6, 0, t); step(1, 0, 0, ex(0, 0, 1, 1, 1));
        end
        set_now(6, 0, 4);   step(1, 0, 0, ex(1, 0, 1, 1, 1));
        step(0, 0, 1, ex(0, 0, 1, 1, 2));
        for (int t = 5; t <= 7; t++) begin
            set_now(6, 0, t); step(1, 0, 0, ex(0, 0, 1, 1, 2));
        end
        set_now(6, 0, 8);   step(1, 0, 0, ex(1, 0, 1, 1, 2));
        set_now(6, 0, 9);   step(1, 0, 0, ex(1, 0, 0, 1, 2));
        step(0, 0, 1, ex(0, 0, 0, 1, 2));

        // Hourly chime with no alarms: 2 ticks of sound, model held afterwards.
        al_en = 4'b0000;
        set_now(11, 0, 0);  step(1, 0, 0, ex(1, 1, 1, 1, 2));
        set_now(11, 0, 1);  step(1, 0, 0, ex(1, 1, 0, 1, 2));
        set_now(11, 0, 2);  step(1, 0, 0, ex(0, 1, 0, 1, 2));

        // Chime preempted by a channel 0 match.
        set_now(12, 0, 0);  step(1, 0, 0, ex(1, 1, 1, 1, 2));
        set_alarm(0, 12, 0, 1);
        al_en = 4'b0001;
        set_now(12, 0, 1);  step(1, 0, 0, ex(1, 0, 1, 0, 0));

        // Stop coinciding with a matching tick while ringing: go idle, ignore match.
        set_alarm(1, 12, 0, 2);
        al_en = 4'b0011;
        set_now(12, 0, 2);  step(1, 1, 0, ex(0, 0, 0, 0, 0));

        // Stop with a matching tick while idle: no trigger.
        set_alarm(1, 12, 0, 3);
        set_now(12, 0, 3);  step(1, 1, 0, ex(0, 0, 0, 0, 0));

        // Enable cleared during snooze.
        set_alarm(0, 12, 5, 0);
        al_en = 4'b0001;
        set_now(12, 5, 0);  step(1, 0, 0, ex(1, 0, 1, 0, 0));
        step(0, 0, 1, ex(0, 0, 1, 0, 1));
        al_en = 4'b0000;
        step(0, 0, 0, ex(0, 0, 0, 0, 1));

        // Reset mid-alarm; a matching tick during reset is ignored.
        set_alarm(2, 12, 10, 0);
        al_en = 4'b0100;
        set_now(12, 10, 0); step(1, 0, 0, ex(1, 0, 1, 2, 0));
        rst = 1'b1;
        step(1, 0, 0, ex(0, 0, 0, 0, 0));
        rst = 1'b0;
        step(0, 0, 0, ex(0, 0, 0, 0, 0));
        set_now(12, 10, 1); step(1, 0, 0, ex(0, 0, 0, 0, 0));

        // Bounded drain of any outstanding expectation.
        tick = 1'b0;
        stop = 1'b0;
        snz  = 1'b0;
        repeat (4) @(negedge clk);
        if (exp_q.size() != 0) begin
            $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
            n_bad = n_bad + exp_q.size();
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/bell_led_ctrl_multi_57.md
Name: bell_led_ctrl_multi_57

Overview:
Parametrised successor to the single-alarm bell controller. It compares the current time against N_ALARM independently enabled alarm registers and generates an hourly chime. It adds a timed ring duration, snooze with a retry limit, a stop request, fixed priority between alarms, and a blinking LED output. It sits between the timekeeping counters and the buzzer/LED drivers, in the same clock domain as the clock core.

Parameters:
N_ALARM, 4, number of alarm channels (1..8)
RING_SEC, 30, alarm ring duration in seconds (>=1)
SNOOZE_SEC, 300, snooze pause in seconds (>=1)
CHIME_SEC, 5, hourly chime duration in seconds (>=1)
MAX_SNOOZE, 3, snoozes allowed per alarm event (>=0)
IDX_W, 2, width of active_idx_57 (>=clog2(N_ALARM), min 1)

Ports:
clk_50m_57  in  1  system clock, 50 MHz
rst_57  in  1  synchronous, active-high reset
sec_tick_57  in  1  one-cycle pulse per second; now_* already hold the new second on this cycle
now_sec_57  in  7  current seconds, binary 0..59
now_min_57  in  7  current minutes, binary 0..59
now_hour_57  in  7  current hours, binary 0..23
alarm_sec_57  in  7*N_ALARM  packed alarm seconds, channel k at [7k+6:7k]
alarm_min_57  in  7*N_ALARM  packed alarm minutes
alarm_hour_57  in  7*N_ALARM  packed alarm hours
alarm_en_57  in  N_ALARM  per-channel enable
chime_en_57  in  1  hourly chime enable
stop_57  in  1  one-cycle stop request
snooze_57  in  1  one-cycle snooze request
sound_e_57  out  1  buzzer enable
sound_model_57  out  1  0 = alarm pattern, 1 = chime pattern
led_57  out  1  indicator LED
active_idx_57  out  IDX_W  channel currently ringing or snoozed
snooze_cnt_57  out  3  snoozes used in the current event

Behaviour:
- Single clock clk_50m_57. Reset rst_57 is synchronous, active-high, and has priority over all other inputs.
- Reset values: state IDLE, all outputs 0, internal counter 0.
- All outputs are registered and reflect the state one cycle after the causing input.
- Match condition for channel k: alarm_en_57[k] is set and sec, min and hour all equal now_*. Matching is evaluated only on cycles where sec_tick_57=1.
- Priority: the lowest matching index wins. Out-of-range alarm values never match and need no special handling.
- Chime condition: chime_en_57=1, now_min_57=0, now_sec_57=0, on a tick. An alarm match always wins over the chime.
- States: IDLE, ALARM, SNOOZE, CHIME.
- Down-counter: width sized for max(RING_SEC, SNOOZE_SEC, CHIME_SEC). Loaded on state entry. Each subsequent tick decrements it; a tick with counter==1 ends the state. Result: a state lasts exactly its parameter's number of ticks.
- IDLE:
  - Tick with an alarm match -> ALARM; load RING_SEC; latch active_idx; snooze_cnt=0.
  - Else tick with the chime condition -> CHIME; load CHIME_SEC.
- ALARM:
  - stop_57 -> IDLE.
  - snooze_57 with snooze_cnt<MAX_SNOOZE -> SNOOZE; load SNOOZE_SEC; snooze_cnt+1.
  - snooze_57 with snooze_cnt==MAX_SNOOZE is treated as stop.
  - Counter expiry -> IDLE.
  - alarm_en_57[active_idx] cleared -> IDLE.
  - A new alarm match on a tick is ignored.
- SNOOZE:
  - Expiry -> ALARM; reload RING_SEC; same index.
  - stop_57 -> IDLE.
  - Enable of the active channel cleared -> IDLE.
  - Tick with a match on any channel -> ALARM with the new index; snooze_cnt=0.
  - Chime condition is ignored; snooze_57 is ignored.
- CHIME:
  - Tick with an alarm match -> ALARM (preempts the chime).
  - stop_57 -> IDLE.
  - Expiry -> IDLE.
  - snooze_57 is ignored.
- Same-cycle precedence: reset > stop > enable-clear > snooze > tick events (match or expiry). When stop_57 coincides with a tick in any state, the next state is IDLE and no new trigger is taken that cycle.
- sound_e_57: 1 in ALARM and CHIME, 0 in IDLE and SNOOZE.
- sound_model_57: set to 0 on ALARM entry and 1 on CHIME entry; otherwise holds its value.
- led_57:
  - On ALARM/CHIME entry: 1, then toggles on every tick while in the state.
  - SNOOZE: steady 1.
  - IDLE: 0.
- active_idx_57 and snooze_cnt_57 hold their values after returning to IDLE, until the next ALARM entry.

Test Plan:
Bench parameters for all scenarios: N_ALARM=4, RING_SEC=3, SNOOZE_SEC=4, CHIME_SEC=2, MAX_SNOOZE=2.
- Ch2 alarm 07:30:00 enabled; tick at now=07:30:00 -> next cycle sound_e=1, model=0, idx=2, led=1; led toggles per tick; sound_e=0 after 3rd subsequent tick.
- Ch1 and ch3 both set to 06:00:00, chime_en=1; tick at 06:00:00 -> ALARM, idx=1, model=0, no chime.
- In ALARM, pulse snooze twice, each ring re-entering after 4 ticks -> snooze_cnt 1 then 2, led steady 1 while snoozed; third snooze -> IDLE, sound_e=0.
- chime_en=1, no alarms; tick at 12:00:00 -> CHIME, model=1, sound_e high for 2 ticks; ch0 matches 12:00:01 -> ALARM, model=0.
- stop_57 and a matching tick on the same cycle while in ALARM -> IDLE, sound_e=0. Clear alarm_en[idx] during SNOOZE -> IDLE next cycle.
- Assert rst_57 mid-ALARM -> next cycle all outputs 0, state IDLE; a tick during reset has no effect.
